jt053245_draw: RTL and testbench
================================

# jt053245_draw

Sprite row drawer directly downstream of the 053244 sprite scanner. On each `dr_start` pulse it latches one 16-pixel tile row descriptor, fetches the 4bpp row from sprite ROM as two 32-bit words, applies horizontal zoom and flip, and writes the non-transparent pixels into the object line buffer. `dr_busy` throttles the scanner.

## Interface
Parameters:
- `BUFW`, 9: line-buffer address width, in pixels.
- `ATTRW`, 10: attribute bits stored with each pixel.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `dr_start` in 1: one-cycle draw request from the scanner.
- `dr_busy` out 1: drawer occupied.
- `code` in 16: tile code.
- `attr` in ATTRW: palette/priority attribute.
- `hflip` in 1: horizontal flip.
- `vflip` in 1: vertical flip.
- `hpos` in 9: tile left x position.
- `ysub` in 4: row within the tile.
- `hzoom` in 12: horizontal zoom, 0x040 = 1:1.
- `hz_keep` in 1: continue from the previous tile.
- `rom_cs` out 1: ROM request.
- `rom_addr` out 21: 32-bit word address.
- `rom_data` in 32: ROM data.
- `rom_ok` in 1: ROM data valid.
- `buf_we` out 1: line-buffer write strobe.
- `buf_addr` out BUFW: write address.
- `buf_din` out ATTRW+4: {attr, pixel}.

## Operation
- States: IDLE, FETCH0, FETCH1, DRAW.
- IDLE, `dr_start`=1:
  - latch all descriptor inputs;
  - compute `yeff` = `vflip` ? ~`ysub` : `ysub`;
  - go to FETCH0.
- IDLE, `dr_start`=0: no change.
- `dr_start` in any state other than IDLE is ignored.
- FETCH0:
  - `rom_cs`=1, `rom_addr`={code, yeff, 1'b0};
  - on the first cycle with `rom_ok`=1, store the word as pixels 0–7 (pixel k = bits [4k+3:4k]) and go to FETCH1.
- FETCH1: same as FETCH0 with address LSB=1, storing pixels 8–15; then `rom_cs`=0 and go to DRAW.
- Zoom step: `step` = `hzoom`[9:0], with 0 forced to 1.
- Accumulator: `acc`, 11 bits, 6 fractional bits.
- DRAW entry:
  - if `hz_keep`=0: `acc`=0 and `xcur`=`hpos`;
  - if `hz_keep`=1: `acc` keeps the previous tile's fractional part (`acc`[5:0]), integer part cleared, and `xcur` keeps the previous tile's end position (`hpos` is ignored).
- DRAW, one output pixel per cycle:
  - `src` = `acc`[9:6], mirrored to 15−`src` when `hflip`;
  - `buf_addr`=`xcur`, `buf_din`={attr, pix[src]};
  - `buf_we`=1 only when the pixel ≠ 0;
  - then `acc`+=`step` and `xcur`+=1.
- DRAW ends, returning to IDLE, when `acc`[10] sets (the source row is exhausted) or after 512 output pixels.
- `xcur` wraps modulo 2^BUFW.

## Timing
- Reset values: `dr_busy`, `rom_cs`, `buf_we`=0; `rom_addr`, `buf_addr`, `buf_din`=0; state IDLE; `acc`=0; `xcur`=0.
- `dr_busy`=1 from the cycle after `dr_start` until the cycle after the last DRAW write. It must be high before the scanner's next `cen2` sample.
- ROM latency: arbitrary. `rom_addr` is held stable while `rom_cs`=1. A `rom_ok` already high on entry to FETCH0 is accepted on that cycle.
- At 1:1 zoom, 16 DRAW cycles follow FETCH1. The minimum request-to-IDLE time is 2 + 16 + 1 cycles.
- Writes are registered: `buf_*` show the pixel for `acc` of the previous cycle.
- Deassertion of `rst_n` mid-fetch or mid-draw forces IDLE immediately, with `rom_cs`=0 and `buf_we`=0.

## Configuration
- `JT053245_CLIP_EN` defined: `buf_we` is suppressed when `xcur` < 0x020 or `xcur` > 0x19F (the visible 384-pixel window). Address and counter advance are unchanged.
- Not defined: every non-zero pixel is written, including wrapped addresses.

## Structure
- Shared package `jt053245_pkg` holds:
  - the state enum;
  - `ZOOM_UNITY`=0x040;
  - `MAX_OUT`=512;
  - clip bounds `CLIP_L`=0x020, `CLIP_R`=0x19F.
- One sub-module, `jt053245_zoomstep`: accumulator, `src` mirror and output-count/termination logic.
- The ROM FSM and latches stay in the top module.

## Test plan
- Single tile at 1:1: `hpos`=0x050, `hzoom`=0x040, ROM words 0x76543210/0xFEDCBA98 → 15 writes at 0x051–0x05F with pixels 1..F; no write at 0x050; `dr_busy` low afterwards.
- `hflip`=1, same data → pixel F written at 0x050 and pixel 1 at 0x05E; no write at 0x05F.
- `hzoom`=0x080 (half size) → 8 output pixels at `hpos`..`hpos`+7 carrying even source pixels; `hzoom`=0x020 → 32 output pixels, each source pixel repeated twice.
- Two tiles with `hzoom`=0x050, second with `hz_keep`=1 and `hpos` +16 → second tile starts at the first tile's end x (`hpos` ignored), with the fraction carried over.
- `rom_ok` delayed 7 cycles, `dr_start` re-pulsed during FETCH1 → second request ignored; `rom_addr` stable; exactly one row drawn.
- `vflip`=1, `ysub`=3 → `rom_addr`={code,4'hC,0} then {code,4'hC,1}. `rst_n` low during DRAW → `buf_we`=0 and `dr_busy`=0 at once. With `JT053245_CLIP_EN`, `hpos`=0x018 suppresses writes to 0x018–0x01F.

Source files
------------

// File: rtl/jt053245_pkg.sv
// jt053245_pkg: shared definitions for the 053245 sprite row drawer.
//   state_t     drawer FSM states
//   ZOOM_UNITY  hzoom value for 1:1 scaling (6 fractional bits)
//   MAX_OUT     hard cap on output pixels per tile row
//   CLIP_L/R    visible window bounds, used when JT053245_CLIP_EN is defined
//   zoom_step   maps hzoom[9:0] to an accumulator step (0 becomes 1)
package jt053245_pkg;

    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} state_t;

    localparam int ZOOM_UNITY = 'h040;
    localparam int MAX_OUT    = 512;
    localparam int CLIP_L     = 'h020;
    localparam int CLIP_R     = 'h19F;

    // A zero step would never exhaust the row, so it is bumped to the smallest step.
    function automatic logic [9:0] zoom_step(input logic [9:0] hz);
        return (hz == '0) ? 10'd1 : hz;
    endfunction

endpackage

// File: rtl/jt053245_draw_zoomstep.sv
// jt053245_zoomstep: horizontal zoom accumulator for one tile row.
//   clk, rst_n  clock, asynchronous active-low reset
//   init_i      load the accumulator for a new row (keep_i: carry fraction)
//   adv_i       one output pixel produced this cycle, advance by step_i
//   hflip_i     mirror the source index
//   src_o       source pixel index for the current output pixel
//   done_o      the current output pixel is the last one of the row
module jt053245_zoomstep
    import jt053245_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_i,
    input  logic       keep_i,
    input  logic       adv_i,
    input  logic       hflip_i,
    input  logic [9:0] step_i,
    output logic [3:0] src_o,
    output logic       done_o
);

    localparam int CNTW = $clog2(MAX_OUT);

    logic [10:0]     acc_q, acc_d;
    logic [CNTW-1:0] cnt_q;

    assign acc_d  = acc_q + {1'b0, step_i};
    // 15 - src is the bitwise complement for a 4-bit index
    assign src_o  = hflip_i ? ~acc_q[9:6] : acc_q[9:6];
    // Row ends when the integer part runs past 15 or the pixel cap is hit
    assign done_o = acc_d[10] | (cnt_q == CNTW'(MAX_OUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (init_i) begin
            // Continuing tiles keep only the sub-pixel phase of the previous row
            acc_q <= keep_i ? {5'b0, acc_q[5:0]} : '0;
            cnt_q <= '0;
        end else if (adv_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

endmodule

// File: rtl/jt053245_draw.sv
// jt053245_draw: sprite row drawer behind the 053244 scanner.
// Latches a tile row descriptor on dr_start, fetches the 4bpp row as two
// 32-bit ROM words, then emits one zoomed/flipped pixel per cycle into the
// object line buffer, skipping transparent (zero) pixels.
//   clk, rst_n          clock, asynchronous active-low reset
//   dr_start/dr_busy    request from / throttle to the scanner
//   code..hz_keep       tile row descriptor
//   rom_cs/addr/data/ok sprite ROM word interface
//   buf_we/addr/din     line-buffer write port, din = {attr, pixel}
// Build option: JT053245_CLIP_EN suppresses writes outside x 0x020..0x19F.
module jt053245_draw
    import jt053245_pkg::*;
#(
    parameter int BUFW  = 9,
    parameter int ATTRW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dr_start,
    output logic             dr_busy,
    input  logic [15:0]      code,
    input  logic [ATTRW-1:0] attr,
    input  logic             hflip,
    input  logic             vflip,
    input  logic [8:0]       hpos,
    input  logic [3:0]       ysub,
    input  logic [11:0]      hzoom,
    input  logic             hz_keep,
    output logic             rom_cs,
    output logic [20:0]      rom_addr,
    input  logic [31:0]      rom_data,
    input  logic             rom_ok,
    output logic             buf_we,
    output logic [BUFW-1:0]  buf_addr,
    output logic [ATTRW+3:0] buf_din
);

    state_t             state_q;
    logic               busy_q, rom_cs_q, we_q;
    logic [20:0]        rom_addr_q;
    logic [BUFW-1:0]    baddr_q, xcur_q;
    logic [ATTRW+3:0]   bdin_q;
    logic [ATTRW-1:0]   attr_q;
    logic               hflip_q, keep_q;
    logic [9:0]         step_q;
    logic [8:0]         hpos_q;
    logic [15:0][3:0]   pix_q;
    logic [3:0]         src, pix;
    logic               done, vis;
    logic               unused_hz;

    // Only the low 10 zoom bits take part in stepping
    assign unused_hz = ^hzoom[11:10];

    jt053245_zoomstep u_zoom (
        .clk     (clk),
        .rst_n   (rst_n),
        .init_i  (state_q == FETCH1 && rom_ok),
        .keep_i  (keep_q),
        .adv_i   (state_q == DRAW),
        .hflip_i (hflip_q),
        .step_i  (step_q),
        .src_o   (src),
        .done_o  (done)
    );

    assign pix = pix_q[src];

`ifdef JT053245_CLIP_EN
    assign vis = (int'(xcur_q) >= CLIP_L) && (int'(xcur_q) <= CLIP_R);
`else
    assign vis = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            we_q       <= 1'b0;
            baddr_q    <= '0;
            bdin_q     <= '0;
            xcur_q     <= '0;
            attr_q     <= '0;
            hflip_q    <= 1'b0;
            keep_q     <= 1'b0;
            step_q     <= 10'd1;
            hpos_q     <= '0;
            pix_q      <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy drops one cycle after the last write is presented
                    busy_q <= dr_start;
                    if (dr_start) begin
                        attr_q     <= attr;
                        hflip_q    <= hflip;
                        keep_q     <= hz_keep;
                        step_q     <= zoom_step(hzoom[9:0]);
                        hpos_q     <= hpos;
                        rom_cs_q   <= 1'b1;
                        rom_addr_q <= {code, vflip ? ~ysub : ysub, 1'b0};
                        state_q    <= FETCH0;
                    end
                end
                FETCH0: if (rom_ok) begin
                    pix_q[7:0]    <= rom_data;
                    rom_addr_q[0] <= 1'b1;
                    state_q       <= FETCH1;
                end
                FETCH1: if (rom_ok) begin
                    pix_q[15:8] <= rom_data;
                    rom_cs_q    <= 1'b0;
                    // hz_keep continues from where the previous row stopped
                    if (!keep_q) xcur_q <= BUFW'(hpos_q);
                    state_q     <= DRAW;
                end
                DRAW: begin
                    we_q    <= (pix != 4'd0) && vis;
                    baddr_q <= xcur_q;
                    bdin_q  <= {attr_q, pix};
                    xcur_q  <= xcur_q + BUFW'(1);
                    if (done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dr_busy  = busy_q;
    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign buf_we   = we_q;
    assign buf_addr = baddr_q;
    assign buf_din  = bdin_q;

endmodule

// File: tb/tb_jt053245_draw.sv
// tb_jt053245_draw: scoreboard bench for jt053245_draw.
// A behavioural row model pushes expected ROM addresses and line-buffer
// writes when each request is issued; a ROM responder and a write monitor
// pop and compare them as the DUT produces them.
// Honours JT053245_CLIP_EN in the model when the design is built with it.
module tb_jt053245_draw;
    import jt053245_pkg::*;

    localparam int BUFW  = 9;
    localparam int ATTRW = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             dr_start = 1'b0;
    logic             dr_busy;
    logic [15:0]      code = '0;
    logic [ATTRW-1:0] attr = '0;
    logic             hflip = 1'b0, vflip = 1'b0, hz_keep = 1'b0;
    logic [8:0]       hpos = '0;
    logic [3:0]       ysub = '0;
    logic [11:0]      hzoom = '0;
    logic             rom_cs, rom_ok;
    logic [20:0]      rom_addr, held;
    logic [31:0]      rom_data;
    logic             buf_we;
    logic [BUFW-1:0]  buf_addr;
    logic [ATTRW+3:0] buf_din;

    logic [31:0] w0, w1, e, ea;
    int          rom_lat = 0, wcnt = 0;
    logic [22:0] exp_wr[$];
    logic [20:0] exp_addr[$];
    int          nvec = 0, nmis = 0;
    logic [5:0]  m_frac = '0;
    logic [8:0]  m_x = '0;

    jt053245_draw #(.BUFW(BUFW), .ATTRW(ATTRW)) dut (
        .clk(clk), .rst_n(rst_n), .dr_start(dr_start), .dr_busy(dr_busy),
        .code(code), .attr(attr), .hflip(hflip), .vflip(vflip), .hpos(hpos),
        .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep), .rom_cs(rom_cs),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit visible(input int x);
`ifdef JT053245_CLIP_EN
        return (x >= CLIP_L) && (x <= CLIP_R);
`else
        return 1'b1;
`endif
    endfunction

    // Reference row model: ROM addresses, then every non-zero output pixel
    task automatic model(input logic [15:0] c, input logic [9:0] a, input logic hf,
                         input logic vf, input logic [8:0] hp, input logic [3:0] ys,
                         input logic [11:0] hz, input logic keep);
        logic [3:0]  ye, p;
        logic [63:0] row;
        int acc, stp, x, n, s;
        ye = vf ? 4'd15 - ys : ys;
        exp_addr.push_back({c, ye, 1'b0});
        exp_addr.push_back({c, ye, 1'b1});
        row = {w1, w0};
        stp = int'(hz[9:0]);
        if (stp == 0) stp = 1;
        acc = keep ? int'(m_frac) : 0;
        x   = keep ? int'(m_x) : int'(hp);
        n   = 0;
        while (acc < 1024 && n < MAX_OUT) begin
            s = acc / 64;
            if (hf) s = 15 - s;
            p = row[s*4 +: 4];
            if (p != 4'd0 && visible(x)) exp_wr.push_back({9'(x), a, p});
            acc += stp;
            x = (x + 1) % 512;
            n++;
        end
        m_frac = 6'(acc % 64);
        m_x    = 9'(x);
    endtask

    // ROM responder: answers after rom_lat waiting cycles, checks address and hold
    initial begin
        rom_ok = 1'b0;
        rom_data = '0;
        forever begin
            @(negedge clk);
            if (rom_cs && rst_n) begin
                if (wcnt == 0) held = rom_addr;
                else chk("rom_hold", {11'b0, rom_addr}, {11'b0, held});
                if (wcnt >= rom_lat) begin
                    rom_ok   = 1'b1;
                    rom_data = rom_addr[0] ? w1 : w0;
                    if (exp_addr.size() != 0) ea = {11'b0, exp_addr.pop_front()};
                    else ea = '1;
                    chk("rom_addr", {11'b0, rom_addr}, ea);
                    wcnt = 0;
                end else begin
                    rom_ok = 1'b0;
                    wcnt++;
                end
            end else begin
                rom_ok = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Line-buffer write monitor
    initial forever begin
        @(negedge clk);
        if (buf_we) begin
            if (exp_wr.size() != 0) e = {9'b0, exp_wr.pop_front()};
            else e = '1;
            chk("buf_wr", {9'b0, buf_addr, buf_din}, e);
        end
    end

    task automatic drive(input logic [15:0] c, input logic [9:0] a, input logic hf,
                         input logic vf, input logic [8:0] hp, input logic [3:0] ys,
                         input logic [11:0] hz, input logic keep);
        model(c, a, hf, vf, hp, ys, hz, keep);
        @(negedge clk);
        code = c; attr = a; hflip = hf; vflip = vf; hpos = hp;
        ysub = ys; hzoom = hz; hz_keep = keep; dr_start = 1'b1;
        @(negedge clk);
        dr_start = 1'b0;
        chk("busy_rise", {31'b0, dr_busy}, 32'd1);
    endtask

    // repulse: loop cycle at which a second (must-be-ignored) request is pulsed
    task automatic draw(input logic [15:0] c, input logic [9:0] a, input logic hf,
                        input logic vf, input logic [8:0] hp, input logic [3:0] ys,
                        input logic [11:0] hz, input logic keep, input int repulse);
        drive(c, a, hf, vf, hp, ys, hz, keep);
        for (int i = 0; i < 3000 && dr_busy; i++) begin
            dr_start = (i == repulse);
            code     = (i == repulse) ? ~c : c;
            @(negedge clk);
        end
        dr_start = 1'b0;
        code = c;
        @(negedge clk);
        chk("busy_fall", {31'b0, dr_busy}, 32'd0);
        chk("wr_left", exp_wr.size(), 32'd0);
        chk("rom_left", exp_addr.size(), 32'd0);
    endtask

    initial begin
        w0 = 32'h76543210;
        w1 = 32'hFEDCBA98;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, dr_busy}, 32'd0);
        chk("rst_rom_cs", {31'b0, rom_cs}, 32'd0);
        chk("rst_we", {31'b0, buf_we}, 32'd0);
        chk("rst_rom_addr", {11'b0, rom_addr}, 32'd0);
        chk("rst_buf", {9'b0, buf_addr, buf_din}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        draw(16'h1234, 10'h155, 0, 0, 9'h050, 4'h2, 12'(ZOOM_UNITY), 0, -1);
        draw(16'h1235, 10'h2AA, 1, 0, 9'h050, 4'h5, 12'(ZOOM_UNITY), 0, -1);
        draw(16'h0001, 10'h001, 0, 0, 9'h100, 4'h0, 12'h080, 0, -1);
        draw(16'h0002, 10'h3FF, 0, 0, 9'h0A0, 4'h7, 12'h020, 0, -1);
        // zero step with high bits set: step 1, capped at MAX_OUT, wraps x
        draw(16'h0003, 10'h011, 0, 0, 9'h1F0, 4'h1, 12'hC00, 0, -1);
        // two chained tiles, second ignores hpos and keeps the fraction
        draw(16'h0010, 10'h0F0, 0, 0, 9'h080, 4'h1, 12'h050, 0, -1);
        draw(16'h0011, 10'h0F1, 0, 0, 9'h090, 4'h1, 12'h050, 1, -1);
        // slow ROM with a stray request during FETCH1
        rom_lat = 7;
        draw(16'hBEEF, 10'h123, 0, 0, 9'h060, 4'h9, 12'(ZOOM_UNITY), 0, 11);
        rom_lat = 0;
        draw(16'h1234, 10'h000, 0, 1, 9'h070, 4'h3, 12'(ZOOM_UNITY), 0, -1);
        draw(16'h4321, 10'h0AA, 0, 0, 9'h1F8, 4'h4, 12'(ZOOM_UNITY), 0, -1);
        draw(16'h4322, 10'h0AB, 0, 0, 9'h018, 4'h4, 12'(ZOOM_UNITY), 0, -1);
        for (int k = 0; k < 4; k++) begin
            w0 = $urandom;
            w1 = $urandom;
            draw(16'($urandom), 10'($urandom), 1'($urandom), 1'($urandom),
                 9'($urandom), 4'($urandom), 12'($urandom_range(16, 200)), 0, -1);
        end

        // reset in the middle of DRAW
        w0 = 32'h76543210;
        w1 = 32'hFEDCBA98;
        drive(16'h0555, 10'h155, 0, 0, 9'h040, 4'h0, 12'(ZOOM_UNITY), 0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstd_we", {31'b0, buf_we}, 32'd0);
        chk("rstd_busy", {31'b0, dr_busy}, 32'd0);
        chk("rstd_cs", {31'b0, rom_cs}, 32'd0);
        exp_wr.delete();
        exp_addr.delete();
        m_frac = '0;
        m_x = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        draw(16'h0556, 10'h2AA, 0, 0, 9'h0C0, 4'h6, 12'(ZOOM_UNITY), 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
